// File: rtl/mux_serial_ctrl.sv
// Serializer that drives an external 8:1 mux (a_out/sel) and samples its output y_in.
// One bit per DIV cycles, eight bits per accepted word, with first/done markers.
//
// state | meaning
// IDLE  | waiting for a word; in_ready high, sel parked at the start index
// SHIFT | stepping sel through the eight inputs and sampling y_in
module mux_serial_ctrl #(
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] a_out,
  output logic [2:0] sel,
  input  logic       y_in,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_first,
  output logic       done
);

  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [2:0]    START    = MSB_FIRST ? 3'd7 : 3'd0;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          accept;
  logic          sample;
  logic          last_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_ready & in_valid;
    sample   = (state == SHIFT) && (div_cnt == DIV_LAST);
    last_bit = sample && (bit_cnt == 3'd7);
  end

  // sel only moves on sample edges, so the mux path has a full bit period to settle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out     <= 8'd0;
      sel       <= 3'd0;
      div_cnt   <= '0;
      bit_cnt   <= 3'd0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      done      <= 1'b0;
    end else begin
      ser_valid <= 1'b0;
      ser_first <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        a_out   <= in_data;
        sel     <= START;
        div_cnt <= '0;
        bit_cnt <= 3'd0;
      end else if (state == SHIFT) begin
        if (sample) begin
          ser_out   <= y_in;
          ser_valid <= 1'b1;
          ser_first <= (bit_cnt == 3'd0);
          div_cnt   <= '0;
          if (last_bit) begin
            done <= 1'b1;
            sel  <= START;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            sel     <= MSB_FIRST ? (sel - 3'd1) : (sel + 3'd1);
          end
        end else begin
          div_cnt <= div_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_serial_ctrl.sv
// Bench for mux_serial_ctrl: four parameterisations, each closed through a behavioural 8:1 mux.
// Frames are table-driven; reset, back-to-back and mid-frame reset are hand-written sequences.
module tb_mux_serial_ctrl;

  localparam int NI = 4;
  localparam int DIVS [NI] = '{1, 4, 2, 3};
  localparam bit MSBS [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       rst_n_v     [NI];
  logic       in_valid_v  [NI];
  logic [7:0] in_data_v   [NI];
  logic       in_ready_v  [NI];
  logic [7:0] a_v         [NI];
  logic [2:0] sel_v       [NI];
  logic       y_v         [NI];
  logic       ser_out_v   [NI];
  logic       ser_valid_v [NI];
  logic       ser_first_v [NI];
  logic       done_v      [NI];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_done_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mux_serial_ctrl #(.DIV(DIVS[g]), .MSB_FIRST(MSBS[g])) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_v[g]),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .in_data  (in_data_v[g]),
      .a_out    (a_v[g]),
      .sel      (sel_v[g]),
      .y_in     (y_v[g]),
      .ser_out  (ser_out_v[g]),
      .ser_valid(ser_valid_v[g]),
      .ser_first(ser_first_v[g]),
      .done     (done_v[g])
    );
    assign y_v[g] = a_v[g][sel_v[g]];
  end

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic [7:0] stream;  // expected bits in emission order, first bit in [7]
    bit         bp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic run_frame(input int i, input logic [7:0] data, input logic [7:0] stream,
                           input bit bp, input bit chain, input logic [7:0] next_data,
                           input bit check_gap);
    int d;
    int n;
    int k;
    int exp_sel;
    bit strobe;
    d = DIVS[i];
    n = 0;
    while (!in_ready_v[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready_v[i]) begin
      chk("ready_timeout", 32'(in_ready_v[i]), 32'd1);
      return;
    end
    in_valid_v[i] = 1'b1;
    in_data_v[i]  = data;
    for (int j = 0; j <= 8 * d; j++) begin
      @(negedge clk);
      strobe = (j > 0) && (j % d == 0);
      k = j / d - 1;
      if (j == 8 * d) exp_sel = MSBS[i] ? 7 : 0;
      else            exp_sel = MSBS[i] ? 7 - j / d : j / d;
      chk("a_out", 32'(a_v[i]), 32'(data));
      chk("sel", 32'(sel_v[i]), 32'(exp_sel));
      chk("ser_valid", 32'(ser_valid_v[i]), 32'(strobe));
      chk("in_ready", 32'(in_ready_v[i]), 32'(j == 8 * d));
      if (strobe) begin
        chk("ser_out", 32'(ser_out_v[i]), 32'(stream[7-k]));
        chk("ser_out_ref", 32'(ser_out_v[i]), 32'(data[MSBS[i] ? 7 - k : k]));
        chk("ser_first", 32'(ser_first_v[i]), 32'(k == 0));
        chk("done", 32'(done_v[i]), 32'(k == 7));
      end else begin
        chk("ser_first_idle", 32'(ser_first_v[i]), 32'd0);
        chk("done_idle", 32'(done_v[i]), 32'd0);
      end
      if (j == 8 * d) begin
        if (check_gap) chk("done_gap", 32'(cyc - last_done_cyc), 32'(8 * d + 1));
        last_done_cyc = cyc;
        in_valid_v[i] = chain;
        in_data_v[i]  = next_data;
      end else begin
        in_valid_v[i] = bp ? 1'($urandom_range(0, 1)) : 1'b0;
        in_data_v[i]  = bp ? 8'($urandom_range(0, 255)) : data;
      end
    end
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, "_a_out"}, 32'(a_v[i]), 32'd0);
    chk({tag, "_sel"}, 32'(sel_v[i]), 32'd0);
    chk({tag, "_ser_out"}, 32'(ser_out_v[i]), 32'd0);
    chk({tag, "_ser_valid"}, 32'(ser_valid_v[i]), 32'd0);
    chk({tag, "_ser_first"}, 32'(ser_first_v[i]), 32'd0);
    chk({tag, "_done"}, 32'(done_v[i]), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready_v[i]), 32'd1);
  endtask

  initial begin
    vecs[0] = '{inst: 0, data: 8'hB4, stream: 8'h2D, bp: 1'b0};
    vecs[1] = '{inst: 1, data: 8'hB4, stream: 8'hB4, bp: 1'b0};
    vecs[2] = '{inst: 0, data: 8'h01, stream: 8'h80, bp: 1'b1};
    vecs[3] = '{inst: 1, data: 8'h01, stream: 8'h01, bp: 1'b1};
    vecs[4] = '{inst: 2, data: 8'hC3, stream: 8'hC3, bp: 1'b1};
    vecs[5] = '{inst: 3, data: 8'hAA, stream: 8'h55, bp: 1'b0};

    for (int i = 0; i < NI; i++) begin
      rst_n_v[i]    = 1'b0;
      in_valid_v[i] = 1'b0;
      in_data_v[i]  = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) chk_reset_vals(i, "rst_hold");
    for (int i = 0; i < NI; i++) rst_n_v[i] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        chk("idle_strobe", 32'(ser_valid_v[i] | done_v[i] | ser_first_v[i]), 32'd0);
        chk("idle_ready", 32'(in_ready_v[i]), 32'd1);
      end
    end
    for (int i = 0; i < NI; i++) chk_reset_vals(i, "rst_idle");

    for (int v = 0; v < 6; v++)
      run_frame(vecs[v].inst, vecs[v].data, vecs[v].stream, vecs[v].bp, 1'b0, 8'h00, 1'b0);

    // back-to-back on DIV=2: second accept lands on the edge right after done
    run_frame(2, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
    run_frame(2, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);

    // mid-frame reset on DIV=3 just after the third strobe
    @(negedge clk);
    in_valid_v[3] = 1'b1;
    in_data_v[3]  = 8'hAA;
    @(negedge clk);
    in_valid_v[3] = 1'b0;
    for (int j = 1; j <= 9; j++) @(negedge clk);
    chk("mid_third_strobe", 32'(ser_valid_v[3]), 32'd1);
    #2 rst_n_v[3] = 1'b0;
    #1 chk_reset_vals(3, "mid_rst");
    repeat (3) @(negedge clk);
    rst_n_v[3] = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'(ser_valid_v[3] | done_v[3]), 32'd0);
    end
    run_frame(3, 8'hAA, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
